// File: rtl/rf_cmd_ctrl.sv
// UART-byte command decoder driving a register file: 0xAA addr data = write, 0xBB addr = read + reply.
// Optional build macro RF_WR_ACK_EN: each completed write also transmits an acknowledge byte 0xAC.
module rf_cmd_ctrl #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned ADDR_W     = 4,
    parameter int unsigned RD_TIMEOUT = 15
) (
    input  logic              CLK,
    input  logic              RST_n,
    input  logic [DATA_W-1:0] RX_P_DATA,
    input  logic              RX_D_VLD,
    input  logic [15:0]       RF_RdData,
    input  logic              RF_RdData_Valid,
    input  logic              TX_BUSY,
    output logic [ADDR_W-1:0] RF_Address,
    output logic              RF_WrEn,
    output logic              RF_RdEn,
    output logic [DATA_W-1:0] RF_WrData,
    output logic [DATA_W-1:0] TX_P_DATA,
    output logic              TX_D_VLD,
    output logic              CMD_ERR
);

    localparam int unsigned CNT_W = ($clog2(RD_TIMEOUT + 1) > 4) ? $clog2(RD_TIMEOUT + 1) : 4;
    localparam logic [DATA_W-1:0] CMD_WR   = DATA_W'(8'hAA);
    localparam logic [DATA_W-1:0] CMD_RD   = DATA_W'(8'hBB);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(RD_TIMEOUT - 1);
`ifdef RF_WR_ACK_EN
    localparam logic [DATA_W-1:0] ACK_BYTE = DATA_W'(8'hAC);
`endif

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_ADDR = 3'd1,
        S_WR_DATA = 3'd2,
        S_WR_STB  = 3'd3,
        S_RD_ADDR = 3'd4,
        S_RD_WAIT = 3'd5,
        S_TX_SEND = 3'd6
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_buf;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_wr_en;
    logic                r_rd_en;
    logic                r_err;

    logic [ADDR_W-1:0]   w_addr_nxt;
    logic [DATA_W-1:0]   w_wdata_nxt;
    logic [DATA_W-1:0]   w_buf_nxt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic                w_wr_en_nxt;
    logic                w_rd_en_nxt;
    logic                w_err_nxt;
    logic                w_bad_cmd;
    logic                w_rx_drop;
    logic                w_timeout;

    generate
        if (DATA_W < 16) begin : g_rd_unused
            logic w_unused_rd_hi;
            assign w_unused_rd_hi = ^RF_RdData[15:DATA_W];
        end
    endgenerate

    // Error sources: unknown opcode, byte arriving while busy, read never answered.
    assign w_bad_cmd = (r_state == S_IDLE) && RX_D_VLD &&
                       (RX_P_DATA != CMD_WR) && (RX_P_DATA != CMD_RD);
    assign w_rx_drop = RX_D_VLD && ((r_state == S_RD_WAIT) || (r_state == S_WR_STB) ||
                                    (r_state == S_TX_SEND));
    assign w_timeout = (r_state == S_RD_WAIT) && !RF_RdData_Valid && (r_cnt == CNT_LAST);

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (RX_D_VLD && (RX_P_DATA == CMD_WR)) begin
                    w_next = S_WR_ADDR;
                end else if (RX_D_VLD && (RX_P_DATA == CMD_RD)) begin
                    w_next = S_RD_ADDR;
                end
            end
            S_WR_ADDR: if (RX_D_VLD) w_next = S_WR_DATA;
            S_WR_DATA: if (RX_D_VLD) w_next = S_WR_STB;
`ifdef RF_WR_ACK_EN
            S_WR_STB:  w_next = S_TX_SEND;
`else
            S_WR_STB:  w_next = S_IDLE;
`endif
            S_RD_ADDR: if (RX_D_VLD) w_next = S_RD_WAIT;
            S_RD_WAIT: begin
                if (RF_RdData_Valid) begin
                    w_next = S_TX_SEND;
                end else if (w_timeout) begin
                    w_next = S_IDLE;
                end
            end
            S_TX_SEND: if (!TX_BUSY) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_addr_nxt  = r_addr;
        w_wdata_nxt = r_wdata;
        w_buf_nxt   = r_buf;
        w_cnt_nxt   = r_cnt;
        w_wr_en_nxt = 1'b0;
        w_rd_en_nxt = 1'b0;
        w_err_nxt   = w_bad_cmd || w_rx_drop || w_timeout;
        case (r_state)
            S_WR_ADDR: if (RX_D_VLD) w_addr_nxt = RX_P_DATA[ADDR_W-1:0];
            S_WR_DATA: begin
                if (RX_D_VLD) begin
                    w_wdata_nxt = RX_P_DATA;
                    w_wr_en_nxt = 1'b1;
                end
            end
`ifdef RF_WR_ACK_EN
            S_WR_STB:  w_buf_nxt = ACK_BYTE;
`endif
            S_RD_ADDR: begin
                if (RX_D_VLD) begin
                    w_addr_nxt  = RX_P_DATA[ADDR_W-1:0];
                    w_rd_en_nxt = 1'b1;
                    w_cnt_nxt   = '0;
                end
            end
            S_RD_WAIT: begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
                if (RF_RdData_Valid) w_buf_nxt = RF_RdData[DATA_W-1:0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_buf   <= '0;
            r_cnt   <= '0;
            r_wr_en <= 1'b0;
            r_rd_en <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_addr  <= w_addr_nxt;
            r_wdata <= w_wdata_nxt;
            r_buf   <= w_buf_nxt;
            r_cnt   <= w_cnt_nxt;
            r_wr_en <= w_wr_en_nxt;
            r_rd_en <= w_rd_en_nxt;
            r_err   <= w_err_nxt;
        end
    end

    assign RF_Address = r_addr;
    assign RF_WrData  = r_wdata;
    assign RF_WrEn    = r_wr_en;
    assign RF_RdEn    = r_rd_en;
    assign CMD_ERR    = r_err;
    assign TX_P_DATA  = r_buf;
    // Follows TX_BUSY within the cycle so a byte is offered on the first idle cycle and never while busy.
    assign TX_D_VLD   = (r_state == S_TX_SEND) && !TX_BUSY;

endmodule

// File: tb/tb_rf_cmd_ctrl.sv
// Testbench for rf_cmd_ctrl: directed command scenarios plus random commands checked
// against a transaction-level expectation of RF strobes, transmitted bytes and errors.
module tb_rf_cmd_ctrl;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 4;
    localparam int unsigned TO = 15;
`ifdef RF_WR_ACK_EN
    localparam int ACK = 1;
`else
    localparam int ACK = 0;
`endif

    logic          CLK = 1'b0;
    logic          RST_n;
    logic [DW-1:0] RX_P_DATA;
    logic          RX_D_VLD;
    logic [15:0]   RF_RdData;
    logic          RF_RdData_Valid;
    logic          TX_BUSY;
    logic [AW-1:0] RF_Address;
    logic          RF_WrEn;
    logic          RF_RdEn;
    logic [DW-1:0] RF_WrData;
    logic [DW-1:0] TX_P_DATA;
    logic          TX_D_VLD;
    logic          CMD_ERR;

    rf_cmd_ctrl #(.DATA_W(DW), .ADDR_W(AW), .RD_TIMEOUT(TO)) dut (
        .CLK(CLK), .RST_n(RST_n),
        .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
        .RF_RdData(RF_RdData), .RF_RdData_Valid(RF_RdData_Valid),
        .TX_BUSY(TX_BUSY),
        .RF_Address(RF_Address), .RF_WrEn(RF_WrEn), .RF_RdEn(RF_RdEn),
        .RF_WrData(RF_WrData), .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD),
        .CMD_ERR(CMD_ERR)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Observed events, recorded mid-cycle while out of reset.
    logic [11:0] wr_q[$];
    logic [3:0]  rd_q[$];
    logic [7:0]  tx_q[$];
    int          err_cnt = 0;
    int          viol    = 0;
    always @(negedge CLK) begin
        if (RST_n) begin
            if (RF_WrEn) wr_q.push_back({RF_Address, RF_WrData});
            if (RF_RdEn) rd_q.push_back(RF_Address);
            if (TX_D_VLD) tx_q.push_back(TX_P_DATA);
            if (CMD_ERR) err_cnt <= err_cnt + 1;
            if ((RF_WrEn && RF_RdEn) || (TX_D_VLD && TX_BUSY)) viol <= viol + 1;
        end
    end

    int n_chk  = 0;
    int n_pass = 0;
    int s_wr, s_rd, s_tx, s_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        tick();
        RX_D_VLD  = 1'b0;
        RX_P_DATA = 8'($urandom);
    endtask

    task automatic snap();
        s_wr  = wr_q.size();
        s_rd  = rd_q.size();
        s_tx  = tx_q.size();
        s_err = err_cnt;
    endtask

    task automatic expect_delta(input string tag, input int dw, input int dr, input int dt, input int de);
        check({tag, ".wr_cnt"},  32'(wr_q.size() - s_wr), 32'(dw));
        check({tag, ".rd_cnt"},  32'(rd_q.size() - s_rd), 32'(dr));
        check({tag, ".tx_cnt"},  32'(tx_q.size() - s_tx), 32'(dt));
        check({tag, ".err_cnt"}, 32'(err_cnt - s_err),     32'(de));
    endtask

    function automatic logic [11:0] wr_at(input int i);
        return (wr_q.size() > i) ? wr_q[i] : 12'hxxx;
    endfunction
    function automatic logic [3:0] rd_at(input int i);
        return (rd_q.size() > i) ? rd_q[i] : 4'hx;
    endfunction
    function automatic logic [7:0] tx_at(input int i);
        return (tx_q.size() > i) ? tx_q[i] : 8'hxx;
    endfunction

    initial begin
        int rc, ec, kind, lat, bsy;
        logic [7:0]  a, d;
        logic [15:0] rdd;
        logic        hit;

        RST_n = 1'b0; RX_P_DATA = '0; RX_D_VLD = 1'b0;
        RF_RdData = '0; RF_RdData_Valid = 1'b0; TX_BUSY = 1'b0;
        repeat (3) tick();
        check("reset.strobes", {28'd0, RF_WrEn, RF_RdEn, TX_D_VLD, CMD_ERR}, 32'd0);
        check("reset.data", {RF_Address, RF_WrData, TX_P_DATA}, 32'd0);
        RST_n = 1'b1;
        repeat (2) tick();

        // Write 0xAA,0x05,0x3C, then an immediate back-to-back write with upper address bits set.
        snap();
        send(8'hAA); send(8'h05); send(8'h3C);
        check("wr.wren", 32'(RF_WrEn), 32'd1);
        check("wr.addr_data", {RF_Address, RF_WrData}, {4'h5, 8'h3C});
        tick();
        check("wr.wren_one_cycle", 32'(RF_WrEn), 32'd0);
        if (ACK == 1) begin
            check("wr.ack_strobe", {TX_D_VLD, TX_P_DATA}, {1'b1, 8'hAC});
            tick();
        end
        send(8'hAA); send(8'hFA); send(8'h55);
        check("b2b.wr", {RF_WrEn, RF_Address, RF_WrData}, {1'b1, 4'hA, 8'h55});
        repeat (3) tick();
        expect_delta("wr", 2, 0, 2 * ACK, 0);
        check("wr.first_event", wr_at(s_wr), {4'h5, 8'h3C});

        // Read 0xBB,0x05, data valid two cycles after the read strobe.
        snap();
        send(8'hBB); send(8'h05);
        check("rd.rden", {RF_RdEn, RF_Address}, {1'b1, 4'h5});
        tick();
        check("rd.rden_one_cycle", 32'(RF_RdEn), 32'd0);
        tick();
        RF_RdData = 16'h003C; RF_RdData_Valid = 1'b1;
        tick();
        RF_RdData_Valid = 1'b0;
        check("rd.tx", {TX_D_VLD, TX_P_DATA}, {1'b1, 8'h3C});
        tick();
        check("rd.tx_one_cycle", 32'(TX_D_VLD), 32'd0);
        expect_delta("rd", 0, 1, 1, 0);

        // Unknown opcode in IDLE.
        snap();
        send(8'h7E);
        check("badcmd.err", 32'(CMD_ERR), 32'd1);
        tick();
        check("badcmd.err_one_cycle", 32'(CMD_ERR), 32'd0);
        tick();
        expect_delta("badcmd", 0, 0, 0, 1);

        // Read with valid never asserted: error exactly TO cycles after entering the wait.
        snap();
        send(8'hBB); send(8'h02);
        rc = cyc;
        for (int i = 0; i < int'(TO) + 5; i++) begin
            if (CMD_ERR) break;
            tick();
        end
        ec = cyc;
        check("timeout.err_seen", 32'(CMD_ERR), 32'd1);
        check("timeout.latency", 32'(ec - rc), 32'(TO));
        repeat (2) tick();
        expect_delta("timeout", 0, 1, 0, 1);

        // Valid in the last wait cycle still wins over the timeout.
        snap();
        send(8'hBB); send(8'h09);
        repeat (TO - 1) tick();
        RF_RdData = 16'hFFA5; RF_RdData_Valid = 1'b1;
        tick();
        RF_RdData_Valid = 1'b0;
        check("lastcycle.tx", {TX_D_VLD, TX_P_DATA, CMD_ERR}, {1'b1, 8'hA5, 1'b0});
        repeat (2) tick();
        expect_delta("lastcycle", 0, 1, 1, 0);

        // Transmitter busy for 10 cycles after the read data arrives.
        snap();
        TX_BUSY = 1'b1;
        send(8'hBB); send(8'h03);
        tick();
        RF_RdData = 16'h005A; RF_RdData_Valid = 1'b1;
        tick();
        RF_RdData_Valid = 1'b0;
        hit = 1'b0;
        repeat (10) begin
            if (TX_D_VLD) hit = 1'b1;
            tick();
        end
        check("busy.no_tx_while_busy", 32'(hit), 32'd0);
        TX_BUSY = 1'b0;
        #1;
        check("busy.tx_first_free", {TX_D_VLD, TX_P_DATA}, {1'b1, 8'h5A});
        tick();
        check("busy.tx_once", 32'(TX_D_VLD), 32'd0);
        expect_delta("busy", 0, 1, 1, 0);

        // Byte arriving during the read wait is dropped with an error; the read still completes.
        snap();
        send(8'hBB); send(8'h06);
        send(8'hAA);
        check("drop.err", 32'(CMD_ERR), 32'd1);
        RF_RdData = 16'h0077; RF_RdData_Valid = 1'b1;
        tick();
        RF_RdData_Valid = 1'b0;
        check("drop.tx", {TX_D_VLD, TX_P_DATA}, {1'b1, 8'h77});
        repeat (2) tick();
        expect_delta("drop", 0, 1, 1, 1);

        // Reset in the middle of a write discards it.
        send(8'hAA); send(8'h07);
        RST_n = 1'b0;
        #1;
        check("midrst.async_clear", {RF_Address, RF_WrEn, CMD_ERR}, 32'd0);
        tick();
        RST_n = 1'b1;
        tick();
        snap();
        send(8'h11);
        check("midrst.err", {CMD_ERR, RF_WrEn}, {1'b1, 1'b0});
        repeat (3) tick();
        expect_delta("midrst", 0, 0, 0, 1);

        // Random commands against the transaction-level expectation.
        for (int t = 0; t < 40; t++) begin
            kind = int'($urandom_range(0, 2));
            a    = 8'($urandom);
            snap();
            if (kind == 0) begin
                d = 8'($urandom);
                send(8'hAA); send(a); send(d);
                repeat (3) tick();
                expect_delta("rnd.wr", 1, 0, ACK, 0);
                check("rnd.wr_val", wr_at(s_wr), {a[3:0], d});
                if (ACK == 1) check("rnd.wr_ack", tx_at(s_tx), 8'hAC);
            end else if (kind == 1) begin
                lat = int'($urandom_range(0, TO + 2));
                bsy = int'($urandom_range(0, 3));
                rdd = 16'($urandom);
                TX_BUSY = (bsy > 0);
                send(8'hBB); send(a);
                repeat (lat) tick();
                RF_RdData = rdd; RF_RdData_Valid = 1'b1;
                tick();
                RF_RdData_Valid = 1'b0;
                repeat (bsy) tick();
                TX_BUSY = 1'b0;
                repeat (TO + 3) tick();
                if (lat < int'(TO)) begin
                    expect_delta("rnd.rd_ok", 0, 1, 1, 0);
                    check("rnd.rd_tx", tx_at(s_tx), rdd[7:0]);
                end else begin
                    expect_delta("rnd.rd_to", 0, 1, 0, 1);
                end
                check("rnd.rd_addr", rd_at(s_rd), a[3:0]);
            end else begin
                while (a == 8'hAA || a == 8'hBB) a = 8'($urandom);
                send(a);
                repeat (2) tick();
                expect_delta("rnd.bad", 0, 0, 0, 1);
            end
        end

        check("global.strobe_rules", 32'(viol), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/rf_cmd_ctrl.md
RF_CMD_CTRL -- requirements
Module: rf_cmd_ctrl

Interface
REQ-001 Parameter DATA_W, default 8, width of command/data bytes and RF write data.
REQ-002 Parameter ADDR_W, default 4, RF address width; address byte bits [ADDR_W-1:0] used, upper bits ignored.
REQ-003 Parameter RD_TIMEOUT, default 15, max cycles waited in RD_WAIT for RF_RdData_Valid.
REQ-004 CLK  input  1  system clock; all state updates on rising edge.
REQ-005 RST_n  input  1  reset, asynchronous, active-low.
REQ-006 RX_P_DATA  input  DATA_W  received UART byte.
REQ-007 RX_D_VLD  input  1  one-cycle strobe, RX_P_DATA valid.
REQ-008 RF_RdData  input  16  RF read data; only bits [DATA_W-1:0] used.
REQ-009 RF_RdData_Valid  input  1  RF read data valid.
REQ-010 TX_BUSY  input  1  UART transmitter busy; no byte issued while high.
REQ-011 RF_Address  output  ADDR_W  RF address.
REQ-012 RF_WrEn / RF_RdEn  output  1 each  RF write/read strobes, never both high.
REQ-013 RF_WrData  output  DATA_W  RF write data.
REQ-014 TX_P_DATA  output  DATA_W  byte to transmit; TX_D_VLD  output  1  one-cycle transmit strobe.
REQ-015 CMD_ERR  output  1  one-cycle error pulse.

Function
REQ-016 States: IDLE, WR_ADDR, WR_DATA, WR_STB, RD_ADDR, RD_WAIT, TX_SEND; only RX_D_VLD-qualified bytes advance command states.
REQ-017 IDLE: byte 0xAA -> WR_ADDR; 0xBB -> RD_ADDR; any other byte -> CMD_ERR pulse next cycle, stay IDLE.
REQ-018 WR_ADDR: on byte, latch address -> WR_DATA.
REQ-019 WR_DATA: on byte, latch data -> WR_STB; in WR_STB RF_WrEn high exactly one cycle with RF_Address/RF_WrData stable, then -> IDLE (or TX_SEND per REQ-030).
REQ-020 RD_ADDR: on byte, latch address, RF_RdEn high exactly one cycle in following cycle, -> RD_WAIT.
REQ-021 RD_WAIT: 4-bit-min counter cleared on entry; RF_RdData_Valid high -> capture RF_RdData[DATA_W-1:0] into TX buffer, -> TX_SEND.
REQ-022 RD_WAIT: counter reaching RD_TIMEOUT with no valid -> CMD_ERR pulse, -> IDLE, nothing transmitted; valid on the timeout cycle wins over timeout.
REQ-023 TX_SEND: when TX_BUSY low, TX_D_VLD high one cycle with TX_P_DATA = buffer, -> IDLE; waits indefinitely while TX_BUSY high.
REQ-024 RX_D_VLD in RD_WAIT, WR_STB or TX_SEND: byte dropped, CMD_ERR pulse, state unaffected.
REQ-025 RF_Address and RF_WrData hold last latched values between commands; RF_RdEn, RF_WrEn, TX_D_VLD, CMD_ERR low in all other cycles.
REQ-026 Minimum latency: write strobe 1 cycle after data byte strobe; read strobe 1 cycle after address byte strobe; TX_D_VLD 1 cycle after RdData_Valid if TX_BUSY low.
REQ-027 Back-to-back commands: a 0xAA/0xBB byte arriving the cycle after return to IDLE is accepted.

Reset
REQ-028 RST_n low: state IDLE, all outputs 0, counter and buffers 0, immediately (asynchronous).
REQ-029 Reset mid-command discards partial command; no strobe issued after release until a new complete command.

Configuration
REQ-030 Macro RF_WR_ACK_EN defined: after WR_STB, buffer loaded with 0xAC and -> TX_SEND (acknowledge byte); undefined: WR_STB -> IDLE, no TX traffic for writes.

Verification
REQ-031 Bytes 0xAA,0x05,0x3C -> one RF_WrEn cycle, Address 5, WrData 0x3C; with RF_WR_ACK_EN, TX_D_VLD with 0xAC.
REQ-032 Bytes 0xBB,0x05; RF_RdData=0x003C valid 2 cycles after RdEn, TX_BUSY low -> one RF_RdEn, Address 5, TX_D_VLD with 0x3C.
REQ-033 Byte 0x7E in IDLE -> CMD_ERR one cycle, no RF or TX strobes.
REQ-034 0xBB,0x02, RF_RdData_Valid held low -> CMD_ERR RD_TIMEOUT cycles after entering RD_WAIT, no TX_D_VLD.
REQ-035 Read completes with TX_BUSY high 10 cycles -> TX_D_VLD asserted on first cycle TX_BUSY low, exactly once.
REQ-036 RST_n pulsed after 0xAA,0x07 -> then 0x11 byte gives CMD_ERR, no RF_WrEn.
